tlb_unit: RTL and testbench

- 16-entry, fully associative, MIPS32-style joint TLB. Sits beside the CP0 register file.
- Sources TLBP results (found/index) and TLBR readout fields into CP0.
- Consumes CP0 EntryHi/EntryLo0/EntryLo1/Index for TLBWI and TLBP.
- Provides two combinational lookup ports: s0 for instruction fetch, s1 for data access.

---
 rtl/tlb_unit.sv | 239 +++++++++++++++++++++++
 tb/tb_tlb_unit.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_unit.sv
// rtl/tlb_unit.sv - 16-entry fully associative MIPS32-style joint TLB
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   s0_* / s1_*                 combinational lookup ports (fetch / data):
//                               vpn2, odd_page, asid in; found, index, pfn, c, d, v out
//   we, w_index, w_entry*       TLBWI write of one entry from CP0 EntryHi/EntryLo0/EntryLo1
//   r_index, r_*                TLBR combinational readout of entry[r_index]
//   tlbp_req, tlbp_hi           TLBP probe request with CP0 EntryHi
//   tlbp_done, tlbp_found/index registered probe result, one cycle after the request

module tlb_unit #(
    parameter int TLBNUM = 16,
    parameter int IDXW   = 4
) (
    input  logic            clk,
    input  logic            reset,

    input  logic [18:0]     s0_vpn2,
    input  logic            s0_odd_page,
    input  logic [7:0]      s0_asid,
    output logic            s0_found,
    output logic [IDXW-1:0] s0_index,
    output logic [19:0]     s0_pfn,
    output logic [2:0]      s0_c,
    output logic            s0_d,
    output logic            s0_v,

    input  logic [18:0]     s1_vpn2,
    input  logic            s1_odd_page,
    input  logic [7:0]      s1_asid,
    output logic            s1_found,
    output logic [IDXW-1:0] s1_index,
    output logic [19:0]     s1_pfn,
    output logic [2:0]      s1_c,
    output logic            s1_d,
    output logic            s1_v,

    input  logic            we,
    input  logic [IDXW-1:0] w_index,
    input  logic [31:0]     w_entryhi,
    input  logic [31:0]     w_entrylo0,
    input  logic [31:0]     w_entrylo1,

    input  logic [IDXW-1:0] r_index,
    output logic [18:0]     r_vpn2,
    output logic [7:0]      r_asid,
    output logic            r_g,
    output logic [19:0]     r_pfn0,
    output logic [2:0]      r_c0,
    output logic            r_d0,
    output logic            r_v0,
    output logic [19:0]     r_pfn1,
    output logic [2:0]      r_c1,
    output logic            r_d1,
    output logic            r_v1,

    input  logic            tlbp_req,
    input  logic [31:0]     tlbp_hi,
    output logic            tlbp_done,
    output logic            tlbp_found,
    output logic [IDXW-1:0] tlbp_index
);

    typedef enum logic [0:0] {
        TLBP_IDLE = 1'b0,
        TLBP_DONE = 1'b1
    } tlbp_state_t;

    logic [18:0] tlb_vpn2 [TLBNUM];
    logic [7:0]  tlb_asid [TLBNUM];
    logic        tlb_g    [TLBNUM];
    logic [19:0] tlb_pfn0 [TLBNUM];
    logic [2:0]  tlb_c0   [TLBNUM];
    logic        tlb_d0   [TLBNUM];
    logic        tlb_v0   [TLBNUM];
    logic [19:0] tlb_pfn1 [TLBNUM];
    logic [2:0]  tlb_c1   [TLBNUM];
    logic        tlb_d1   [TLBNUM];
    logic        tlb_v1   [TLBNUM];

    logic [TLBNUM-1:0] s0_match;
    logic [TLBNUM-1:0] s1_match;
    logic [TLBNUM-1:0] tp_match;

    tlbp_state_t state_q;
    tlbp_state_t state_d;

    // EntryHi[12:8] and the EntryLo fill bits carry nothing the TLB stores.
    logic unused_bits;
    assign unused_bits = ^{w_entryhi[12:8], w_entrylo0[31:26], w_entrylo1[31:26], tlbp_hi[12:8]};

    // Lowest set bit wins when several entries match; no match gives index 0.
    function automatic logic [IDXW-1:0] first_hit(input logic [TLBNUM-1:0] m);
        logic [IDXW-1:0] idx;
        idx = '0;
        for (int i = TLBNUM - 1; i >= 0; i--) begin
            if (m[i]) idx = i[IDXW-1:0];
        end
        return idx;
    endfunction

    // Entry storage. Global bit is the AND of both EntryLo G bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < TLBNUM; i++) begin
                tlb_vpn2[i] <= '0;
                tlb_asid[i] <= '0;
                tlb_g[i]    <= 1'b0;
                tlb_pfn0[i] <= '0;
                tlb_c0[i]   <= '0;
                tlb_d0[i]   <= 1'b0;
                tlb_v0[i]   <= 1'b0;
                tlb_pfn1[i] <= '0;
                tlb_c1[i]   <= '0;
                tlb_d1[i]   <= 1'b0;
                tlb_v1[i]   <= 1'b0;
            end
        end else if (we) begin
            tlb_vpn2[w_index] <= w_entryhi[31:13];
            tlb_asid[w_index] <= w_entryhi[7:0];
            tlb_g[w_index]    <= w_entrylo0[0] & w_entrylo1[0];
            tlb_pfn0[w_index] <= w_entrylo0[25:6];
            tlb_c0[w_index]   <= w_entrylo0[5:3];
            tlb_d0[w_index]   <= w_entrylo0[2];
            tlb_v0[w_index]   <= w_entrylo0[1];
            tlb_pfn1[w_index] <= w_entrylo1[25:6];
            tlb_c1[w_index]   <= w_entrylo1[5:3];
            tlb_d1[w_index]   <= w_entrylo1[2];
            tlb_v1[w_index]   <= w_entrylo1[1];
        end
    end

    // Match vectors for the two lookup ports and the probe.
    always_comb begin
        s0_match = '0;
        s1_match = '0;
        tp_match = '0;
        for (int i = 0; i < TLBNUM; i++) begin
            s0_match[i] = (tlb_vpn2[i] == s0_vpn2) && (tlb_g[i] || (tlb_asid[i] == s0_asid));
            s1_match[i] = (tlb_vpn2[i] == s1_vpn2) && (tlb_g[i] || (tlb_asid[i] == s1_asid));
            tp_match[i] = (tlb_vpn2[i] == tlbp_hi[31:13]) &&
                          (tlb_g[i] || (tlb_asid[i] == tlbp_hi[7:0]));
        end
    end

    // Fetch port: page attributes come from the even or odd half of the hit entry.
    always_comb begin
        s0_found = |s0_match;
        s0_index = first_hit(s0_match);
        s0_pfn   = '0;
        s0_c     = '0;
        s0_d     = 1'b0;
        s0_v     = 1'b0;
        if (s0_found) begin
            if (s0_odd_page) begin
                s0_pfn = tlb_pfn1[s0_index];
                s0_c   = tlb_c1[s0_index];
                s0_d   = tlb_d1[s0_index];
                s0_v   = tlb_v1[s0_index];
            end else begin
                s0_pfn = tlb_pfn0[s0_index];
                s0_c   = tlb_c0[s0_index];
                s0_d   = tlb_d0[s0_index];
                s0_v   = tlb_v0[s0_index];
            end
        end
    end

    // Data port, independent of the fetch port.
    always_comb begin
        s1_found = |s1_match;
        s1_index = first_hit(s1_match);
        s1_pfn   = '0;
        s1_c     = '0;
        s1_d     = 1'b0;
        s1_v     = 1'b0;
        if (s1_found) begin
            if (s1_odd_page) begin
                s1_pfn = tlb_pfn1[s1_index];
                s1_c   = tlb_c1[s1_index];
                s1_d   = tlb_d1[s1_index];
                s1_v   = tlb_v1[s1_index];
            end else begin
                s1_pfn = tlb_pfn0[s1_index];
                s1_c   = tlb_c0[s1_index];
                s1_d   = tlb_d0[s1_index];
                s1_v   = tlb_v0[s1_index];
            end
        end
    end

    // TLBR readout.
    always_comb begin
        r_vpn2 = tlb_vpn2[r_index];
        r_asid = tlb_asid[r_index];
        r_g    = tlb_g[r_index];
        r_pfn0 = tlb_pfn0[r_index];
        r_c0   = tlb_c0[r_index];
        r_d0   = tlb_d0[r_index];
        r_v0   = tlb_v0[r_index];
        r_pfn1 = tlb_pfn1[r_index];
        r_c1   = tlb_c1[r_index];
        r_d1   = tlb_d1[r_index];
        r_v1   = tlb_v1[r_index];
    end

    // TLBP sequencing. The probe samples tp_match at the same edge a TLBWI
    // lands, so it always sees pre-write contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= TLBP_IDLE;
            tlbp_found <= 1'b0;
            tlbp_index <= '0;
        end else begin
            state_q <= state_d;
            if (tlbp_req) begin
                tlbp_found <= |tp_match;
                tlbp_index <= first_hit(tp_match);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        tlbp_done = 1'b0;
        case (state_q)
            TLBP_IDLE: begin
                if (tlbp_req) state_d = TLBP_DONE;
            end
            TLBP_DONE: begin
                tlbp_done = 1'b1;
                if (!tlbp_req) state_d = TLBP_IDLE;
            end
            default: state_d = TLBP_IDLE;
        endcase
    end

endmodule

// File: tb/tb_tlb_unit.sv
// tb/tb_tlb_unit.sv - randomized self-checking bench for tlb_unit

module tb_tlb_unit;

    logic        clk;
    logic        reset;
    logic [18:0] s0_vpn2, s1_vpn2;
    logic        s0_odd_page, s1_odd_page;
    logic [7:0]  s0_asid, s1_asid;
    logic        s0_found, s1_found;
    logic [3:0]  s0_index, s1_index;
    logic [19:0] s0_pfn, s1_pfn;
    logic [2:0]  s0_c, s1_c;
    logic        s0_d, s1_d, s0_v, s1_v;
    logic        we;
    logic [3:0]  w_index;
    logic [31:0] w_entryhi, w_entrylo0, w_entrylo1;
    logic [3:0]  r_index;
    logic [18:0] r_vpn2;
    logic [7:0]  r_asid;
    logic        r_g;
    logic [19:0] r_pfn0, r_pfn1;
    logic [2:0]  r_c0, r_c1;
    logic        r_d0, r_v0, r_d1, r_v1;
    logic        tlbp_req;
    logic [31:0] tlbp_hi;
    logic        tlbp_done, tlbp_found;
    logic [3:0]  tlbp_index;

    tlb_unit dut (
        .clk(clk), .reset(reset),
        .s0_vpn2(s0_vpn2), .s0_odd_page(s0_odd_page), .s0_asid(s0_asid),
        .s0_found(s0_found), .s0_index(s0_index), .s0_pfn(s0_pfn),
        .s0_c(s0_c), .s0_d(s0_d), .s0_v(s0_v),
        .s1_vpn2(s1_vpn2), .s1_odd_page(s1_odd_page), .s1_asid(s1_asid),
        .s1_found(s1_found), .s1_index(s1_index), .s1_pfn(s1_pfn),
        .s1_c(s1_c), .s1_d(s1_d), .s1_v(s1_v),
        .we(we), .w_index(w_index), .w_entryhi(w_entryhi),
        .w_entrylo0(w_entrylo0), .w_entrylo1(w_entrylo1),
        .r_index(r_index), .r_vpn2(r_vpn2), .r_asid(r_asid), .r_g(r_g),
        .r_pfn0(r_pfn0), .r_c0(r_c0), .r_d0(r_d0), .r_v0(r_v0),
        .r_pfn1(r_pfn1), .r_c1(r_c1), .r_d1(r_d1), .r_v1(r_v1),
        .tlbp_req(tlbp_req), .tlbp_hi(tlbp_hi),
        .tlbp_done(tlbp_done), .tlbp_found(tlbp_found), .tlbp_index(tlbp_index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic chk_en = 1'b0;

    // Model keeps the raw CP0 words written to each slot; fields are
    // extracted from them only when a lookup or readout needs them.
    logic [31:0] m_hi  [16];
    logic [31:0] m_lo0 [16];
    logic [31:0] m_lo1 [16];
    logic        exp_done;
    logic        exp_found;
    logic [3:0]  exp_index;

    typedef struct packed {
        logic        found;
        logic [3:0]  index;
        logic [19:0] pfn;
        logic [2:0]  c;
        logic        d;
        logic        v;
    } res_t;

    function automatic res_t model_lookup(input logic [18:0] vpn2, input logic odd,
                                          input logic [7:0] asid);
        res_t r;
        logic [31:0] lo;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            if (!r.found && m_hi[i][31:13] == vpn2 &&
                ((m_lo0[i][0] & m_lo1[i][0]) || m_hi[i][7:0] == asid)) begin
                r.found = 1'b1;
                r.index = i[3:0];
                lo      = odd ? m_lo1[i] : m_lo0[i];
                r.pfn   = lo[25:6];
                r.c     = lo[5:3];
                r.d     = lo[2];
                r.v     = lo[1];
            end
        end
        return r;
    endfunction

    function automatic logic [4:0] probe(input logic [31:0] hi);
        res_t r;
        r = model_lookup(hi[31:13], 1'b0, hi[7:0]);
        return {r.found, r.index};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                m_hi[i]  <= '0;
                m_lo0[i] <= '0;
                m_lo1[i] <= '0;
            end
            exp_done  <= 1'b0;
            exp_found <= 1'b0;
            exp_index <= '0;
        end else begin
            if (we) begin
                m_hi[w_index]  <= w_entryhi;
                m_lo0[w_index] <= w_entrylo0;
                m_lo1[w_index] <= w_entrylo1;
            end
            exp_done <= tlbp_req;
            if (tlbp_req) {exp_found, exp_index} <= probe(tlbp_hi);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("s0", {s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v},
                  model_lookup(s0_vpn2, s0_odd_page, s0_asid));
            check("s1", {s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v},
                  model_lookup(s1_vpn2, s1_odd_page, s1_asid));
            check("r_hi", {r_vpn2, r_asid, r_g},
                  {m_hi[r_index][31:13], m_hi[r_index][7:0], m_lo0[r_index][0] & m_lo1[r_index][0]});
            check("r_lo0", {r_pfn0, r_c0, r_d0, r_v0}, m_lo0[r_index][25:1]);
            check("r_lo1", {r_pfn1, r_c1, r_d1, r_v1}, m_lo1[r_index][25:1]);
            check("tlbp", {tlbp_done, tlbp_found, tlbp_index}, {exp_done, exp_found, exp_index});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] idx, input logic [31:0] hi, input logic [31:0] lo0,
                      input logic [31:0] lo1);
        we = 1'b1; w_index = idx; w_entryhi = hi; w_entrylo0 = lo0; w_entrylo1 = lo1;
    endtask

    logic [18:0] vpn_pool [4];
    logic [31:0] hdup, h7, h2;

    initial begin
        vpn_pool[0] = 19'h00000; vpn_pool[1] = 19'h00201;
        vpn_pool[2] = 19'h091A2; vpn_pool[3] = 19'h7FFFF;
        hdup = 32'h1234_5077; h7 = 32'h0ABC_D033; h2 = 32'hFFFF_E0A5;
        reset = 1'b1; we = 1'b0; w_index = '0; w_entryhi = '0; w_entrylo0 = '0; w_entrylo1 = '0;
        s0_vpn2 = '0; s0_odd_page = 1'b0; s0_asid = '0;
        s1_vpn2 = '0; s1_odd_page = 1'b0; s1_asid = '0;
        r_index = '0; tlbp_req = 1'b0; tlbp_hi = '0;
        step(); step();
        reset = 1'b0; chk_en = 1'b1;

        // All-zero entries after reset match vpn2=0/asid=0 at index 0.
        settle();
        check("lit_reset_s0", {s0_found, s0_index, s0_v}, {1'b1, 4'd0, 1'b0});
        check("lit_reset_done", tlbp_done, 1'b0);

        // Global entry at index 5, odd page.
        step(); wr(4'd5, 32'h0040_2012, 32'h0000_1047, 32'h0000_2047);
        step(); we = 1'b0;
        s1_vpn2 = 19'h00201; s1_asid = 8'h12; s1_odd_page = 1'b1; r_index = 4'd5;
        settle();
        check("lit_idx5_s1", {s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v},
              {1'b1, 4'd5, 20'h00081, 3'd0, 1'b1, 1'b1});
        check("lit_idx5_g", r_g, 1'b1);

        // Non-global rewrite: ASID must now match.
        step(); wr(4'd5, 32'h0040_2012, 32'h0000_1047, 32'h0000_2046);
        step(); we = 1'b0; s1_asid = 8'h13;
        settle();
        check("lit_asid_miss", s1_found, 1'b0);
        s1_asid = 8'h12; #1;
        check("lit_asid_hit", {s1_found, s1_index}, {1'b1, 4'd5});
        check("lit_nong_g", r_g, 1'b0);

        // Duplicates: lowest index wins for search and probe.
        step(); wr(4'd3, hdup, 32'h0000_0806, 32'h0);
        step(); wr(4'd9, hdup, 32'h0000_0806, 32'h0);
        step(); we = 1'b0; s0_vpn2 = hdup[31:13]; s0_asid = hdup[7:0];
        settle();
        check("lit_dup_s0", {s0_found, s0_index}, {1'b1, 4'd3});
        step(); tlbp_req = 1'b1; tlbp_hi = hdup;
        step(); tlbp_req = 1'b0;
        settle();
        check("lit_dup_tlbp", {tlbp_done, tlbp_found, tlbp_index}, {1'b1, 1'b1, 4'd3});

        // Write and probe in the same cycle: probe sees old contents.
        step(); wr(4'd7, h7, 32'h0000_0043, 32'h0); tlbp_req = 1'b1; tlbp_hi = h7;
        step(); we = 1'b0;
        settle();
        check("lit_same_cycle", {tlbp_done, tlbp_found}, {1'b1, 1'b0});
        step(); tlbp_req = 1'b0;
        settle();
        check("lit_back_to_back", {tlbp_done, tlbp_found, tlbp_index}, {1'b1, 1'b1, 4'd7});

        // TLBR readout, then reset clears it and the pending probe result.
        step(); wr(4'd2, h2, 32'h03FF_FFFF, 32'h0155_5555);
        step(); we = 1'b0; r_index = 4'd2;
        settle();
        check("lit_tlbr_hi", {r_vpn2, r_asid, r_g}, {19'h7FFFF, 8'hA5, 1'b1});
        check("lit_tlbr_lo0", {r_pfn0, r_c0, r_d0, r_v0}, {20'hFFFFF, 3'd7, 1'b1, 1'b1});
        check("lit_tlbr_lo1", {r_pfn1, r_c1, r_d1, r_v1}, {20'h55555, 3'd2, 1'b1, 1'b0});
        step(); tlbp_req = 1'b1; tlbp_hi = h2;
        step(); reset = 1'b1;
        settle();
        check("lit_pre_reset_tlbp", {tlbp_done, tlbp_found, tlbp_index}, {1'b1, 1'b1, 4'd2});
        step(); reset = 1'b0; tlbp_req = 1'b0;
        settle();
        check("lit_post_reset", {r_vpn2, r_pfn0, tlbp_done, tlbp_found}, {19'h0, 20'h0, 1'b0, 1'b0});

        // Randomized traffic over a small VPN/ASID space so hits and duplicates are common.
        for (int n = 0; n < 3000; n++) begin
            step();
            reset       = ($urandom_range(0, 299) == 0);
            we          = ($urandom_range(0, 2) == 0);
            w_index     = 4'($urandom);
            w_entryhi   = {vpn_pool[$urandom_range(0, 3)], 5'($urandom), 8'($urandom_range(0, 2))};
            w_entrylo0  = $urandom;
            w_entrylo1  = $urandom;
            tlbp_req    = ($urandom_range(0, 2) == 0);
            tlbp_hi     = {vpn_pool[$urandom_range(0, 3)], 5'($urandom), 8'($urandom_range(0, 2))};
            s0_vpn2     = vpn_pool[$urandom_range(0, 3)];
            s0_odd_page = 1'($urandom);
            s0_asid     = 8'($urandom_range(0, 2));
            s1_vpn2     = vpn_pool[$urandom_range(0, 3)];
            s1_odd_page = 1'($urandom);
            s1_asid     = 8'($urandom_range(0, 2));
            r_index     = 4'($urandom);
        end
        step();
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
